// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes SPI command/address/data frames into an 8-bit register bank with read-back
module spi_reg_bridge #(
   parameter int NUM_REGS = 16,
   parameter logic [7:0] RESET_VAL = 8'h00,
   parameter logic [7:0] ERR_READ_VAL = 8'hEE
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  ss,
   input  logic                  rx_rdy,
   input  logic [7:0]            rx_byte,
   output logic [7:0]            tx_byte,
   output logic                  tx_latch,
   output logic [NUM_REGS*8-1:0] regs_flat,
   output logic                  wr_pulse,
   output logic [6:0]            wr_addr,
   output logic                  err
);
   localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] NR = 8'(NUM_REGS);
   localparam logic [6:0] LAST = 7'(NUM_REGS - 1);
   typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
   state_t state, state_nx;
   logic [1:0] ss_sy, rdy_sy;
   logic rdy_d, ss_s, byte_evt, do_wr, do_ld, ld, wr_hit, rd_hit;
   logic [6:0] addr, addr_nx;
   logic [7:0] regs [NUM_REGS];
   function automatic logic [6:0] inc(input logic [6:0] a);
      return a == LAST ? 7'd0 : a + 7'd1;
   endfunction
   assign ss_s = ss_sy[1];
   assign byte_evt = rdy_sy[1] & ~rdy_d;
   assign wr_hit = {1'b0, addr} < NR;
   assign rd_hit = {1'b0, addr_nx} < NR;
   always_comb begin
      state_nx = state;
      addr_nx = addr;
      do_wr = 1'b0;
      do_ld = 1'b0;
      if (!ss_s) state_nx = IDLE;
      else if (state == IDLE) state_nx = CMD;
      else if (byte_evt) begin
         if (state == CMD) begin
            addr_nx = rx_byte[6:0];
            state_nx = rx_byte[7] ? RD : WR;
            do_ld = rx_byte[7];
         end else begin
            addr_nx = inc(addr);
            do_wr = state == WR;
            do_ld = state == RD;
         end
      end
   end
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= IDLE;
         ss_sy <= 2'b00;
         rdy_sy <= 2'b00;
         rdy_d <= 1'b0;
         addr <= 7'd0;
         tx_byte <= 8'h00;
         ld <= 1'b0;
         tx_latch <= 1'b0;
         wr_pulse <= 1'b0;
         wr_addr <= 7'd0;
         err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else begin
         ss_sy <= {ss_sy[0], ss};
         rdy_sy <= {rdy_sy[0], rx_rdy};
         rdy_d <= rdy_sy[1];
         state <= state_nx;
         addr <= addr_nx;
         ld <= do_ld;
         tx_latch <= ld;
         wr_pulse <= do_wr & wr_hit;
         if (do_wr && wr_hit) begin
            regs[addr[AW-1:0]] <= rx_byte;
            wr_addr <= addr;
         end
         // tx_byte is set up one cycle ahead of tx_latch
         if (do_ld) tx_byte <= rd_hit ? regs[addr_nx[AW-1:0]] : ERR_READ_VAL;
         if ((do_wr && !wr_hit) || (do_ld && !rd_hit)) err <= 1'b1;
      end
   end
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[8*i +: 8] = regs[i];
   end
endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of the SPI slave shifter, in the sys_clk domain.
- Consumes each received byte (rx_byte with its rx_rdy flag) and decodes a command/address/data frame protocol.
- Writes or reads an internal bank of 8-bit control registers.
- Returns read data to the shifter through tx_byte plus a tx_latch pulse.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; legal 2..128.
- RESET_VAL, 8'h00, reset value of every register.
- ERR_READ_VAL, 8'hEE, byte returned on a read of an unmapped address.

Ports:
- sys_clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- ss, input, 1, slave select from pad, active-high (frame active); asynchronous.
- rx_rdy, input, 1, byte-complete flag from the shifter; asynchronous, level held while the byte is valid.
- rx_byte, input, 8, received byte from the shifter; stable while rx_rdy is high.
- tx_byte, output, 8, byte to be loaded into the shifter.
- tx_latch, output, 1, one-cycle pulse; the shifter loads tx_byte on its rising edge.
- regs_flat, output, NUM_REGS*8, register contents; reg i occupies bits [8i+7:8i].
- wr_pulse, output, 1, one-cycle strobe on each committed register write.
- wr_addr, output, 7, address of the last committed write.
- err, output, 1, sticky flag set on any unmapped access; cleared only by rst.

Behaviour:
- Reset: rst is sampled on posedge sys_clk and has priority over everything else.
  - All registers return to RESET_VAL.
  - tx_byte=8'h00, tx_latch=0, wr_pulse=0, wr_addr=0, err=0.
  - FSM goes to IDLE and the address pointer is cleared.
  - Synchronizer flops are cleared to 0.
  - A reset asserted mid-frame aborts the frame; no write is committed in that cycle.
- Synchronization:
  - ss and rx_rdy each pass through a 2-flop synchronizer.
  - byte_evt = rising edge of synchronized rx_rdy, a single-cycle pulse.
  - rx_byte is captured in the byte_evt cycle with no extra synchronizer; it is guaranteed stable because rx_rdy is already high.
- Frame protocol:
  - First byte after ss rises is CMD: bit7 = 1 for read, 0 for write; bits[6:0] = start address.
  - Subsequent bytes are data.
  - The address auto-increments after each data byte and wraps from NUM_REGS-1 to 0.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE -> CMD when synced ss=1.
  - CMD on byte_evt: latch addr; go to RD if bit7=1, else WR.
  - WR on byte_evt: if addr < NUM_REGS, write reg[addr] <= rx_byte, pulse wr_pulse and set wr_addr=addr; otherwise drop the byte and set err. Then addr <= wrap(addr+1).
  - RD: see read timing below.
  - Any state -> IDLE in the cycle after synced ss=0. A partial frame leaves already-committed writes intact.
- Read timing:
  - On entering RD from CMD, tx_byte <= value(addr) in the same cycle as the transition. value(addr) is reg[addr], or ERR_READ_VAL with err set when addr >= NUM_REGS.
  - tx_latch pulses the following cycle, so tx_byte is set up one cycle before tx_latch and held until the next update.
  - Each later byte_evt in RD (the master's dummy byte) advances addr and repeats the load-then-latch sequence for the new address.
  - Read data therefore appears on MISO starting with the byte after CMD.
- Latency:
  - rx_rdy rising to wr_pulse/register update: 3 sys_clk cycles (2 sync + 1).
  - rx_rdy rising to tx_latch: 4 cycles.
- Simultaneous events:
  - byte_evt in the same cycle synced ss falls: the byte is discarded and the FSM goes to IDLE.
  - byte_evt while in IDLE: ignored.
- Register writes occur only from the WR state. wr_pulse is never high for two consecutive cycles unless two byte_evts are consecutive.
- wr_addr and the address pointer are 7 bits. Wrap compares against NUM_REGS; never rely on modulo 128.

Test Plan:
- Reset with NUM_REGS=16: assert rst 2 cycles -> regs_flat all 0, tx_latch=0, err=0, state IDLE.
- ss=1, bytes 8'h03, 8'hA5, 8'h5A -> reg3=A5, reg4=5A; two wr_pulse strobes, each 3 cycles after its rx_rdy rise; wr_addr ends at 3'h4.
- Preload reg15=8'h11 and reg0=8'h22; frame 8'h8F, dummy, dummy -> tx_byte=11 with tx_latch 4 cycles after the CMD rx_rdy; then tx_byte=22 (wrap to 0), then reg1's value.
- Write frame 8'h20, 8'h77 -> no register changes, no wr_pulse, err=1; read frame 8'hA0 -> tx_byte=EE.
- Drop ss after CMD 8'h05 plus one data byte 8'h3C, then assert rst mid-frame -> reg5 first reads 3C, then is cleared to 00 by rst; FSM returns to IDLE; a new frame decodes its first byte as CMD.
- rx_rdy edge in the same cycle synced ss falls -> no write and no tx_latch.
